// File: rtl/uart_tx_framer.sv
// UART transmit engine: ready/valid word in, start/data/parity/stop frames out.
// A one-word hold register lets the next frame start right after the last stop cycle.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] D_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] L_STOP = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_framer: illegal parameter set");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] hold, hold_n, shreg, shreg_n;
  logic                 hold_full, hold_full_n, par_bit, par_n, tx_n;
  logic                 wrap, last_stop, accept, load;

  assign wrap      = (timer == T_LAST);
  assign last_stop = (state == ST_STOP) && wrap && (idx == L_STOP);
  assign accept    = tx_valid && !hold_full;
  // Accept and load are exclusive: one needs hold empty, the other hold full.
  assign load      = hold_full && ((state == ST_IDLE) || last_stop);

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      idx       <= '0;
      hold      <= '0;
      shreg     <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      idx       <= idx_n;
      hold      <= hold_n;
      shreg     <= shreg_n;
      hold_full <= hold_full_n;
      par_bit   <= par_n;
      tx        <= tx_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    shreg_n     = shreg;
    par_n       = par_bit;
    hold_n      = hold;
    hold_full_n = hold_full;
    timer_n     = (state == ST_IDLE || wrap) ? '0 : timer + 1'b1;
    if (accept) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end
    case (state)
      ST_START: if (wrap) begin
        state_n = ST_DATA;
        idx_n   = '0;
      end
      ST_DATA: if (wrap) begin
        shreg_n = shreg >> 1;
        idx_n   = idx + 1'b1;
        if (idx == D_LAST) begin
          state_n = (PARITY != 0) ? ST_PAR : ST_STOP;
          idx_n   = '0;
        end
      end
      ST_PAR: if (wrap) begin
        state_n = ST_STOP;
        idx_n   = '0;
      end
      ST_STOP: if (wrap) begin
        idx_n = idx + 1'b1;
        if (idx == L_STOP) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (load) begin
      shreg_n     = hold;
      par_n       = (^hold) ^ (PARITY == 2);
      hold_full_n = 1'b0;
      state_n     = ST_START;
      timer_n     = '0;
      idx_n       = '0;
    end
  end

  // tx is registered from the next-state view so it changes on the entry edge.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shreg_n[0];
      ST_PAR:   tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  assign tx_ready   = !hold_full;
  assign busy       = (state != ST_IDLE) || hold_full;
  assign frame_done = last_stop;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: four framer variants at 4 clocks/bit, frames sampled on the falling edge.
module tb_uart_tx_framer;
  logic       gclk, grst_n;
  logic [3:0] vld, txs, fds, bsy, rdy;
  logic [8:0] dat [4];
  int         n_cmp, n_bad, fd_cnt0;

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  always @(posedge gclk) if (fds[0]) fd_cnt0 <= fd_cnt0 + 1;

  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
    .CLOCK_50(gclk), .Reset_n(grst_n), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]), .frame_done(fds[0]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e81 (
    .CLOCK_50(gclk), .Reset_n(grst_n), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]), .frame_done(fds[1]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o81 (
    .CLOCK_50(gclk), .Reset_n(grst_n), .tx_data(dat[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]), .frame_done(fds[2]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_o72 (
    .CLOCK_50(gclk), .Reset_n(grst_n), .tx_data(dat[3][6:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]), .frame_done(fds[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Send one word from idle and check the whole frame; exp holds bit b of the line at [b].
  task automatic send_chk(input int d, input logic [8:0] w, input int nb,
                          input logic [31:0] exp, input string tag);
    logic        smp [64];
    logic [31:0] got;
    int          len, nbad, fdc, fdpos;
    len = nb * 4; nbad = 0; fdc = 0; fdpos = -1; got = '0;
    @(negedge gclk); vld[d] = 1'b1; dat[d] = w;
    @(negedge gclk); vld[d] = 1'b0;
    chk({tag, "_pre_tx"}, 32'(txs[d]), 1);
    chk({tag, "_pre_busy"}, 32'(bsy[d]), 1);
    chk({tag, "_pre_rdy"}, 32'(rdy[d]), 0);
    for (int k = 0; k < len; k++) begin
      @(negedge gclk);
      smp[k] = txs[d];
      if (fds[d]) begin fdc++; fdpos = k; end
    end
    for (int b = 0; b < nb; b++) got[b] = smp[b*4+2];
    for (int k = 0; k < len; k++) if (smp[k] !== smp[(k/4)*4+2]) nbad++;
    chk({tag, "_frame"}, got, exp);
    chk({tag, "_bitwidth"}, 32'(nbad), 0);
    chk({tag, "_fd_cnt"}, 32'(fdc), 1);
    chk({tag, "_fd_pos"}, 32'(fdpos), 32'(len - 1));
    @(negedge gclk);
    chk({tag, "_post_busy"}, 32'(bsy[d]), 0);
    chk({tag, "_post_tx"}, 32'(txs[d]), 1);
  endtask

  initial begin
    logic [8:0]  words [3];
    logic        smp [120];
    logic        fsm [120];
    logic        rsm [120];
    logic [31:0] f0, f1, f2;
    int          fdc, lows, fd_before;
    n_cmp = 0; n_bad = 0; fd_cnt0 = 0;
    grst_n = 1'b0; vld = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (3) @(negedge gclk);
    chk("rst_tx", 32'(txs), 32'hF);
    chk("rst_rdy", 32'(rdy), 32'hF);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_fd", 32'(fds), 0);
    grst_n = 1'b1;

    send_chk(0, 9'h0A5, 10, 32'h34A, "n81_a5");
    send_chk(1, 9'h007, 11, 32'h60E, "e81_07");
    send_chk(2, 9'h007, 11, 32'h40E, "o81_07");
    send_chk(1, 9'h000, 11, 32'h400, "e81_00");
    send_chk(3, 9'h055, 11, 32'h7AA, "o72_55");

    // Back-to-back with valid held high; data is junk whenever ready is low.
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
    fork
      begin
        int wi = 0;
        while (wi < 3) begin
          @(negedge gclk);
          vld[0] = 1'b1;
          if (rdy[0]) begin dat[0] = words[wi]; wi++; end
          else dat[0] = 9'($urandom_range(0, 255));
        end
        @(negedge gclk); vld[0] = 1'b0;
      end
      begin
        @(negedge gclk);
        @(negedge gclk);
        chk("b2b_pre_tx", 32'(txs[0]), 1);
        chk("b2b_pre_rdy", 32'(rdy[0]), 0);
        for (int k = 0; k < 120; k++) begin
          @(negedge gclk);
          smp[k] = txs[0]; fsm[k] = fds[0]; rsm[k] = rdy[0];
        end
      end
    join
    f0 = '0; f1 = '0; f2 = '0; fdc = 0;
    for (int b = 0; b < 10; b++) begin
      f0[b] = smp[b*4+2]; f1[b] = smp[40+b*4+2]; f2[b] = smp[80+b*4+2];
    end
    for (int k = 0; k < 120; k++) if (fsm[k]) fdc++;
    chk("b2b_f0", f0, 32'h222);
    chk("b2b_f1", f1, 32'h244);
    chk("b2b_f2", f2, 32'h266);
    chk("b2b_fd_cnt", 32'(fdc), 3);
    chk("b2b_fd_pos", {29'd0, fsm[39], fsm[79], fsm[119]}, 32'h7);
    chk("b2b_start2", {30'd0, smp[39], smp[40]}, 32'h2);
    chk("b2b_rdy", {28'd0, rsm[0], rsm[1], rsm[40], rsm[41]}, 32'hA);
    @(negedge gclk);
    chk("b2b_post_busy", 32'(bsy[0]), 0);

    // Reset mid-DATA while a second word sits in hold.
    @(negedge gclk); vld[0] = 1'b1; dat[0] = 9'h05A;
    @(negedge gclk); dat[0] = 9'h077;
    @(negedge gclk);
    @(negedge gclk); vld[0] = 1'b0;
    repeat (4) @(negedge gclk);
    chk("rst_pre_tx", 32'(txs[0]), 0);
    chk("rst_pre_rdy", 32'(rdy[0]), 0);
    fd_before = fd_cnt0;
    #2 grst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(txs[0]), 1);
    chk("rst_mid_rdy", 32'(rdy[0]), 1);
    chk("rst_mid_busy", 32'(bsy[0]), 0);
    chk("rst_mid_fd", 32'(fds[0]), 0);
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge gclk);
      if (!txs[0]) lows++;
    end
    chk("rst_after_lows", 32'(lows), 0);
    chk("rst_after_fd", 32'(fd_cnt0 - fd_before), 0);
    chk("rst_after_busy", 32'(bsy[0]), 0);
    send_chk(0, 9'h03C, 10, 32'h278, "n81_3c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit engine: accepts parallel words over a ready/valid handshake and serialises them as start bit, LSB-first data, optional parity and one or two stop bits at a fixed bit period. It replaces the fixed 8N1 load/enable controller and its separate bit timer with one self-contained block. It includes a one-word holding register so that back-to-back frames go out with no idle gap. It sits between the accumulator/result logic and the board TX pin.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- Illegal parameter values are an elaboration error.

- CLOCK_50  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  word to send. Sampled only on an accept edge.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  holding register empty. Equals !hold_full.
- tx  out  1  serial line, registered. Idles high.
- busy  out  1  high when the state is not IDLE or hold_full = 1.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- Accept: a rising edge with tx_valid = 1 and tx_ready = 1 writes tx_data into the hold register and sets hold_full.
  - tx_valid without tx_ready has no effect.
  - The source must hold tx_data stable until the word is accepted.
- States:
  - IDLE: tx = 1.
    - If hold_full: load the shift register from hold, clear hold_full, compute the parity bit from the loaded word, and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles.
    - After the last data bit, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles, then STOP.
    - Even: the bit is the XOR of the data bits.
    - Odd: the bit is the inverse of that XOR.
  - STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles. frame_done is asserted on the final cycle.
    - If hold_full on that cycle: load as in IDLE and go directly to START (no idle bit).
    - Otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Cleared on every state entry and at each bit boundary.
  - Its wrap is the only bit-advance event.
- Bit index counter: width $clog2(DATA_BITS+1). Counts data bits; clears on entry to DATA.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles. 8N1 at the defaults gives 4340 cycles.
- Simultaneous load and accept: tx_ready derives from the registered hold_full.
  - On the cycle the engine empties hold, tx_ready is still 0.
  - A new word is accepted one cycle later, at the earliest.
  - After a load, the hold register can take the next word during the current frame.

## Timing
- Reset (Reset_n low, asynchronous) forces:
  - state = IDLE, hold_full = 0, both counters = 0;
  - outputs tx = 1, tx_ready = 1, busy = 0, frame_done = 0.
- Reset mid-frame: tx goes high immediately without waiting for a clock. The frame in flight and any held word are discarded.
- Release is synchronous in effect: the first accept is possible on the first rising edge with Reset_n high.
- Latency from an idle block: accept at edge N, load at edge N+1, tx low from just after edge N+1.
- busy rises just after edge N and falls on the edge after frame_done when hold is empty.
- Throughput with tx_valid held high: frames are contiguous. The start bit follows the last stop cycle directly; tx never shows a high cycle beyond the stop bits.
- frame_done is exactly 1 cycle wide, once per frame.

## Test plan
- CLKS_PER_BIT=4, 8N1; send 0xA5 from idle:
  - tx low starts 1 cycle after the accept edge;
  - the line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide, 40 cycles total;
  - one frame_done pulse; busy drops afterwards.
- 8E1, send 0x07: parity bit = 1. 8O1, send 0x07: parity bit = 0. 8E1, send 0x00: parity bit = 0. Frame length is 44 cycles (CLKS_PER_BIT=4).
- DATA_BITS=7, PARITY=2, STOP_BITS=2; send 0x55: frame is 11 bits, and tx stays high for 8 cycles at the end.
- Back-to-back, 8N1, tx_valid held high with 0x11 then 0x22:
  - the second word is accepted during frame 1 and tx_ready falls;
  - frame 2's start bit begins on the cycle after frame 1's frame_done;
  - a third word waits until tx_ready returns.
- Assert Reset_n low in the middle of the DATA state while a word is held: tx = 1 immediately, tx_ready = 1, busy = 0, and no frame_done. After release, a fresh 0x3C transmits correctly.
- Toggle tx_data while tx_ready = 0 and tx_valid = 1: only the value present on the accept edge is transmitted.
